// File: rtl/ibex_multdiv_arb_if.sv
// rtl/ibex_multdiv_arb_if.sv - request, response and datapath bundle for the multdiv arbiter
interface ibex_multdiv_arb_if;
   logic        req0_valid_i, req1_valid_i;
   logic        req0_ready_o, req1_ready_o;
   logic [1:0]  req0_operator_i, req1_operator_i;
   logic [1:0]  req0_signed_mode_i, req1_signed_mode_i;
   logic [31:0] req0_op_a_i, req1_op_a_i;
   logic [31:0] req0_op_b_i, req1_op_b_i;
   logic        rsp0_valid_o, rsp1_valid_o;
   logic        rsp0_ready_i, rsp1_ready_i;
   logic [31:0] rsp0_result_o, rsp1_result_o;
   logic        md_mult_en_o, md_div_en_o;
   logic [1:0]  md_operator_o, md_signed_mode_o;
   logic [31:0] md_op_a_o, md_op_b_o;
   logic        md_valid_i;
   logic [31:0] md_result_i;

   modport slave (
      input  req0_valid_i, req1_valid_i, req0_operator_i, req1_operator_i,
             req0_signed_mode_i, req1_signed_mode_i, req0_op_a_i, req1_op_a_i,
             req0_op_b_i, req1_op_b_i, rsp0_ready_i, rsp1_ready_i,
             md_valid_i, md_result_i,
      output req0_ready_o, req1_ready_o, rsp0_valid_o, rsp1_valid_o,
             rsp0_result_o, rsp1_result_o, md_mult_en_o, md_div_en_o,
             md_operator_o, md_signed_mode_o, md_op_a_o, md_op_b_o
   );

   modport master (
      output req0_valid_i, req1_valid_i, req0_operator_i, req1_operator_i,
             req0_signed_mode_i, req1_signed_mode_i, req0_op_a_i, req1_op_a_i,
             req0_op_b_i, req1_op_b_i, rsp0_ready_i, rsp1_ready_i,
             md_valid_i, md_result_i,
      input  req0_ready_o, req1_ready_o, rsp0_valid_o, rsp1_valid_o,
             rsp0_result_o, rsp1_result_o, md_mult_en_o, md_div_en_o,
             md_operator_o, md_signed_mode_o, md_op_a_o, md_op_b_o
   );
endinterface

// File: rtl/ibex_multdiv_arb.sv
// rtl/ibex_multdiv_arb.sv - round-robin arbiter sharing one multdiv datapath between two requesters
module ibex_multdiv_arb (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   ibex_multdiv_arb_if.slave     bus,
   output logic                  busy_o,
   output logic                  owner_o
);
   localparam logic [1:0] MD_OP_MULL = 2'd0;
   localparam logic [1:0] MD_OP_MULH = 2'd1;
   localparam logic [1:0] MD_OP_DIV  = 2'd2;
   localparam logic [1:0] MD_OP_REM  = 2'd3;

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

   state_e      state_q, state_d;
   logic        prio_q;
   logic        owner_q;
   logic [1:0]  operator_q, signed_mode_q;
   logic [31:0] op_a_q, op_b_q;
   logic [31:0] rsp0_result_q, rsp1_result_q;
   logic        req_any, gnt_idx, accept, capture, rsp_ready_sel;

   always_comb begin
      state_d       = state_q;
      req_any       = bus.req0_valid_i | bus.req1_valid_i;
      // Contention goes to the preferred side; otherwise whoever is asking.
      gnt_idx       = (bus.req0_valid_i & bus.req1_valid_i) ? prio_q : bus.req1_valid_i;
      accept        = 1'b0;
      capture       = 1'b0;
      rsp_ready_sel = owner_q ? bus.rsp1_ready_i : bus.rsp0_ready_i;
      unique case (state_q)
         IDLE: if (req_any) begin
            accept  = 1'b1;
            state_d = BUSY;
         end
         BUSY: if (bus.md_valid_i) begin
            capture = 1'b1;
            state_d = RESP;
         end
         RESP: if (rsp_ready_sel) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= IDLE;
         prio_q        <= 1'b0;
         owner_q       <= 1'b0;
         operator_q    <= 2'd0;
         signed_mode_q <= 2'd0;
         op_a_q        <= 32'd0;
         op_b_q        <= 32'd0;
         rsp0_result_q <= 32'd0;
         rsp1_result_q <= 32'd0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            owner_q       <= gnt_idx;
            prio_q        <= ~gnt_idx;
            operator_q    <= gnt_idx ? bus.req1_operator_i    : bus.req0_operator_i;
            signed_mode_q <= gnt_idx ? bus.req1_signed_mode_i : bus.req0_signed_mode_i;
            op_a_q        <= gnt_idx ? bus.req1_op_a_i        : bus.req0_op_a_i;
            op_b_q        <= gnt_idx ? bus.req1_op_b_i        : bus.req0_op_b_i;
         end
         if (capture && !owner_q) rsp0_result_q <= bus.md_result_i;
         if (capture &&  owner_q) rsp1_result_q <= bus.md_result_i;
      end
   end

   assign bus.req0_ready_o     = (state_q == IDLE) & req_any & ~gnt_idx;
   assign bus.req1_ready_o     = (state_q == IDLE) & req_any &  gnt_idx;
   assign bus.rsp0_valid_o     = (state_q == RESP) & ~owner_q;
   assign bus.rsp1_valid_o     = (state_q == RESP) &  owner_q;
   assign bus.rsp0_result_o    = rsp0_result_q;
   assign bus.rsp1_result_o    = rsp1_result_q;
   // Enables follow the state, so they drop the cycle after md_valid_i.
   assign bus.md_mult_en_o     = (state_q == BUSY) &
                                 ((operator_q == MD_OP_MULL) | (operator_q == MD_OP_MULH));
   assign bus.md_div_en_o      = (state_q == BUSY) &
                                 ((operator_q == MD_OP_DIV) | (operator_q == MD_OP_REM));
   assign bus.md_operator_o    = operator_q;
   assign bus.md_signed_mode_o = signed_mode_q;
   assign bus.md_op_a_o        = op_a_q;
   assign bus.md_op_b_o        = op_b_q;
   assign busy_o               = (state_q != IDLE);
   assign owner_o              = owner_q;

   state_legal_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
      state_q inside {IDLE, BUSY, RESP});
endmodule

// File: doc/ibex_multdiv_arb.md
IBEX_MULTDIV_ARB -- requirements
Module: ibex_multdiv_arb

Interface
REQ-001 The block SHALL use these ports: clk_i, input, 1, clock; rst_ni, input, 1, reset, asynchronous, active-low.
REQ-002 The block SHALL have these requester ports, for N in {0,1}:
  - reqN_valid_i, input, 1, request present.
  - reqN_ready_o, output, 1, request accepted this cycle.
  - reqN_operator_i, input, 2, ibex_pkg::md_op_e operator.
  - reqN_signed_mode_i, input, 2, signedness: bit0 selects A, bit1 selects B.
  - reqN_op_a_i, input, 32, operand A.
  - reqN_op_b_i, input, 32, operand B.
REQ-003 The block SHALL have these response ports, for N in {0,1}:
  - rspN_valid_o, output, 1, result held for requester N.
  - rspN_ready_i, input, 1, requester N consumes the result.
  - rspN_result_o, output, 32, result.
REQ-004 The block SHALL have these datapath ports:
  - md_mult_en_o, output, 1, multiply enable.
  - md_div_en_o, output, 1, divide enable.
  - md_operator_o, output, 2, operator.
  - md_signed_mode_o, output, 2, signedness.
  - md_op_a_o, output, 32, operand A.
  - md_op_b_o, output, 32, operand B.
  - md_valid_i, input, 1, datapath result valid.
  - md_result_i, input, 32, datapath result.
REQ-005 The block SHALL have these status ports:
  - busy_o, output, 1, high when the FSM is not in IDLE.
  - owner_o, output, 1, index of the requester currently served.

Function
REQ-006 The block SHALL implement an FSM with states IDLE, BUSY and RESP.
REQ-007 The block SHALL hold a 1-bit round-robin pointer, prio_q, that names the preferred requester.
REQ-008 In IDLE, the block SHALL grant as follows:
  - Only one reqN_valid_i high: that requester is granted.
  - Both high: requester prio_q is granted.
  - reqN_ready_o is combinational and is high only for the granted requester in IDLE.
REQ-009 On the accept cycle (valid & ready) the block SHALL:
  - Register operator, signed_mode, op_a and op_b into the md_* output registers.
  - Set owner_o to the granted index.
  - Set prio_q to the inverse of the granted index.
  - Enter BUSY.
REQ-010 In BUSY, the block SHALL drive md_mult_en_o = 1 for MD_OP_MULL/MD_OP_MULH and md_div_en_o = 1 for MD_OP_DIV/MD_OP_REM.
REQ-011 Both enables SHALL be 0 in every other state; they are never both 1.
REQ-012 The md_* operand, operator and signed-mode outputs SHALL remain stable from the accept cycle until the block leaves BUSY.
REQ-013 In BUSY, when md_valid_i = 1, the block SHALL capture md_result_i into the response register of owner_o and enter RESP.
REQ-014 The enables SHALL be 0 in the cycle after md_valid_i, so the datapath returns to its idle state without starting a new operation.
REQ-015 md_valid_i SHALL be ignored outside BUSY.
REQ-016 In RESP, rspN_valid_o SHALL be 1 only for N = owner_o, with rspN_result_o holding the captured value.
REQ-017 In RESP, on rspN_ready_i = 1 the block SHALL return to IDLE; otherwise it SHALL hold RESP indefinitely (backpressure).
REQ-018 rspN_result_o SHALL remain stable while rspN_valid_o = 1.
REQ-019 No request SHALL be accepted in BUSY or RESP; the earliest next accept is the cycle after the response handshake.
REQ-020 Latency from accept to rsp_valid SHALL be the datapath latency + 1 cycle (result register).
REQ-021 The block SHALL add no arithmetic and SHALL pass results unmodified, including the division-by-zero results produced by the datapath.
REQ-022 reqN_valid_i falling without a handshake SHALL NOT cause a grant or any state change.
REQ-023 busy_o SHALL equal (state != IDLE).
REQ-024 owner_o SHALL hold its last value while in IDLE.

Reset
REQ-025 On rst_ni low, the block SHALL asynchronously reset as follows:
  - FSM = IDLE, prio_q = 0, owner_o = 0.
  - All md_* outputs = 0.
  - rspN_valid_o = 0 and rspN_result_o = 0.
REQ-026 Reset asserted in BUSY or RESP SHALL discard the operation and pending response, with no rsp_valid after reset release.
REQ-027 The first cycle after reset release SHALL accept requests.
REQ-028 The FSM state SHALL always be one of IDLE/BUSY/RESP; this SHALL be checked by an assertion.

Verification
REQ-029 req0 MULL, A = 3, B = 5 -> md_mult_en_o = 1 from the cycle after accept; rsp0_valid_o with result 0x0000000F; rsp1_valid_o stays 0.
REQ-030 Both valid in the first cycle after reset, req0 DIV 100/7 and req1 REM 100/7 -> req0 served first with result 14, then req1 with result 2; prio_q = 0 after the second grant.
REQ-031 req1 DIV, B = 0 -> rsp1_result_o = 0xFFFFFFFF; req1 REM, A = 9, B = 0 -> result 9.
REQ-032 rsp0_ready_i held low for 10 cycles after rsp0_valid_o -> result stable; req1_ready_o = 0 throughout; req1 is accepted the cycle after the handshake.
REQ-033 rst_ni pulsed mid-BUSY on a MULH -> all outputs 0 immediately; no rsp_valid afterwards; a new MULL 0xFFFFFFFF*2 then completes with result 0xFFFFFFFE.
REQ-034 Random interleaved traffic, compared against a reference model -> no lost or duplicated responses and results correct; under continuous contention no requester waits more than one other operation.
